id_stage: RTL and testbench

Instruction-decode stage of the five-stage MIPS pipeline. It sits directly downstream of the IF stage and consumes its IF/ID outputs: the next-instruction address and the current instruction. It holds the 32×32 register file, decodes the opcode into control signals, and detects load-use hazards, which stall IF. All results are registered into an internal ID/EX pipeline register that drives the EX stage.

---
 rtl/mips_pkg.sv | 67 ++++++
 rtl/id_reg_file.sv | 37 +++
 rtl/id_stage.sv | 95 +++++++++
 tb/tb_id_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU operation classes and control bundle.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instructions that read rt as a source operand (I-type loads/addi only write it).
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_reg_file.sv
// 32x32 register file: two asynchronous read ports with write-back bypass, one write port.
module id_reg_file
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] rd_idx_a,
  input  logic [REG_IDX_W-1:0] rd_idx_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b
);

  logic [DATA_W-1:0] regs [32];

  // NOTE: the array is reset because every register must read 0 after reset;
  // this costs a flop-based array instead of an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wr_idx != '0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_IDX_W-1:0] idx);
    if (idx == '0)                        return '0;
    else if (we && (wr_idx == idx))       return wr_data;
    else                                  return regs[idx];
  endfunction

  assign rd_data_a = read_port(rd_idx_a);
  assign rd_data_b = read_port(rd_idx_b);

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, register read, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] NEXT_INS_ADR_IN,
  input  logic [31:0] CUR_INS_IN,
  input  logic        WB_REG_WRITE,
  input  logic [4:0]  WB_WRITE_REG,
  input  logic [31:0] WB_WRITE_DATA,
  input  logic        FLUSH,
  output logic        STALL,
  output logic [31:0] NEXT_INS_ADR_OUT,
  output logic [31:0] READ_DATA_1_OUT,
  output logic [31:0] READ_DATA_2_OUT,
  output logic [31:0] SIGN_EXT_IMM_OUT,
  output logic [4:0]  RS_OUT,
  output logic [4:0]  RT_OUT,
  output logic [4:0]  RD_OUT,
  output logic        REG_DST_OUT,
  output logic        ALU_SRC_OUT,
  output logic        MEM_TO_REG_OUT,
  output logic        REG_WRITE_OUT,
  output logic        MEM_READ_OUT,
  output logic        MEM_WRITE_OUT,
  output logic        BRANCH_OUT,
  output logic [1:0]  ALU_OP_OUT
);

  logic [5:0]           opcode;
  logic [REG_IDX_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]    rd_data_1, rd_data_2, imm_ext;
  logic                 hazard, bubble;
  ctrl_t                ctrl_q;

  assign opcode  = CUR_INS_IN[31:26];
  assign rs      = CUR_INS_IN[25:21];
  assign rt      = CUR_INS_IN[20:16];
  assign rd      = CUR_INS_IN[15:11];
  assign imm_ext = {{16{CUR_INS_IN[15]}}, CUR_INS_IN[15:0]};

  id_reg_file u_reg_file (
    .clk       (CLK),
    .rst_n     (RST_N),
    .we        (WB_REG_WRITE),
    .wr_idx    (WB_WRITE_REG),
    .wr_data   (WB_WRITE_DATA),
    .rd_idx_a  (rs),
    .rd_idx_b  (rt),
    .rd_data_a (rd_data_1),
    .rd_data_b (rd_data_2)
  );

  // A load in EX whose destination feeds this instruction must wait one cycle.
  assign hazard = ctrl_q.mem_read && (RT_OUT != '0) &&
                  ((RT_OUT == rs) || ((RT_OUT == rt) && uses_rt(opcode)));
  assign STALL  = hazard && !FLUSH;
  assign bubble = hazard || FLUSH;

  // NOTE: pipeline state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctrl_q           <= '0;
      NEXT_INS_ADR_OUT <= '0;
      READ_DATA_1_OUT  <= '0;
      READ_DATA_2_OUT  <= '0;
      SIGN_EXT_IMM_OUT <= '0;
      RS_OUT           <= '0;
      RT_OUT           <= '0;
      RD_OUT           <= '0;
    end else begin
      ctrl_q           <= bubble ? ctrl_t'('0) : decode(opcode);
      NEXT_INS_ADR_OUT <= NEXT_INS_ADR_IN;
      READ_DATA_1_OUT  <= rd_data_1;
      READ_DATA_2_OUT  <= rd_data_2;
      SIGN_EXT_IMM_OUT <= imm_ext;
      RS_OUT           <= rs;
      RT_OUT           <= rt;
      RD_OUT           <= rd;
    end
  end

  assign REG_DST_OUT    = ctrl_q.reg_dst;
  assign ALU_SRC_OUT    = ctrl_q.alu_src;
  assign MEM_TO_REG_OUT = ctrl_q.mem_to_reg;
  assign REG_WRITE_OUT  = ctrl_q.reg_write;
  assign MEM_READ_OUT   = ctrl_q.mem_read;
  assign MEM_WRITE_OUT  = ctrl_q.mem_write;
  assign BRANCH_OUT     = ctrl_q.branch;
  assign ALU_OP_OUT     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed vector bench for id_stage: table of per-cycle vectors plus reset sequences.
module tb_id_stage;

  logic        CLK, RST_N;
  logic [31:0] NEXT_INS_ADR_IN, CUR_INS_IN, WB_WRITE_DATA;
  logic        WB_REG_WRITE, FLUSH;
  logic [4:0]  WB_WRITE_REG;
  logic        STALL;
  logic [31:0] NEXT_INS_ADR_OUT, READ_DATA_1_OUT, READ_DATA_2_OUT, SIGN_EXT_IMM_OUT;
  logic [4:0]  RS_OUT, RT_OUT, RD_OUT;
  logic        REG_DST_OUT, ALU_SRC_OUT, MEM_TO_REG_OUT, REG_WRITE_OUT;
  logic        MEM_READ_OUT, MEM_WRITE_OUT, BRANCH_OUT;
  logic [1:0]  ALU_OP_OUT;

  id_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .NEXT_INS_ADR_IN(NEXT_INS_ADR_IN), .CUR_INS_IN(CUR_INS_IN),
    .WB_REG_WRITE(WB_REG_WRITE), .WB_WRITE_REG(WB_WRITE_REG), .WB_WRITE_DATA(WB_WRITE_DATA),
    .FLUSH(FLUSH), .STALL(STALL),
    .NEXT_INS_ADR_OUT(NEXT_INS_ADR_OUT), .READ_DATA_1_OUT(READ_DATA_1_OUT),
    .READ_DATA_2_OUT(READ_DATA_2_OUT), .SIGN_EXT_IMM_OUT(SIGN_EXT_IMM_OUT),
    .RS_OUT(RS_OUT), .RT_OUT(RT_OUT), .RD_OUT(RD_OUT),
    .REG_DST_OUT(REG_DST_OUT), .ALU_SRC_OUT(ALU_SRC_OUT), .MEM_TO_REG_OUT(MEM_TO_REG_OUT),
    .REG_WRITE_OUT(REG_WRITE_OUT), .MEM_READ_OUT(MEM_READ_OUT), .MEM_WRITE_OUT(MEM_WRITE_OUT),
    .BRANCH_OUT(BRANCH_OUT), .ALU_OP_OUT(ALU_OP_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}
  localparam logic [8:0] C_NOP  = 9'b0_0_0_0_0_0_0_00;
  localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
  localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
  localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
  localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
  localparam logic [8:0] C_ADDI = 9'b0_1_0_1_0_0_0_00;

  logic [8:0] ctrl_act;
  assign ctrl_act = {REG_DST_OUT, ALU_SRC_OUT, MEM_TO_REG_OUT, REG_WRITE_OUT,
                     MEM_READ_OUT, MEM_WRITE_OUT, BRANCH_OUT, ALU_OP_OUT};

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        flush;
    logic        stall;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [8:0]  ctrl;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   miscompares = 0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic add(input string name, input logic [31:0] ins, input logic we,
                     input logic [4:0] wreg, input logic [31:0] wdata, input logic flush,
                     input logic stall, input logic [4:0] rs, rt, rd,
                     input logic [31:0] rd1, rd2, imm, input logic [8:0] ctrl);
    vec_t v;
    v.name = name; v.ins = ins; v.we = we; v.wreg = wreg; v.wdata = wdata;
    v.flush = flush; v.stall = stall; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.ctrl = ctrl;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, 32'(STALL), 32'd0);
    check({tag, ".ctrl"},  32'(ctrl_act), 32'd0);
    check({tag, ".pc"},    NEXT_INS_ADR_OUT, 32'd0);
    check({tag, ".rd1"},   READ_DATA_1_OUT, 32'd0);
    check({tag, ".rd2"},   READ_DATA_2_OUT, 32'd0);
    check({tag, ".imm"},   SIGN_EXT_IMM_OUT, 32'd0);
    check({tag, ".fields"}, {17'd0, RS_OUT, RT_OUT, RD_OUT}, 32'd0);
  endtask

  task automatic drive(input logic [31:0] pc, ins, input logic we, input logic [4:0] wreg,
                       input logic [31:0] wdata, input logic flush);
    NEXT_INS_ADR_IN = pc; CUR_INS_IN = ins; WB_REG_WRITE = we;
    WB_WRITE_REG = wreg; WB_WRITE_DATA = wdata; FLUSH = flush;
  endtask

  task automatic apply(input vec_t v, input logic [31:0] pc);
    @(negedge CLK);
    drive(pc, v.ins, v.we, v.wreg, v.wdata, v.flush);
    #1;
    check({v.name, ".stall"}, 32'(STALL), 32'(v.stall));
    @(posedge CLK);
    #1;
    n_vec++;
    check({v.name, ".pc"},   NEXT_INS_ADR_OUT, pc);
    check({v.name, ".rd1"},  READ_DATA_1_OUT, v.rd1);
    check({v.name, ".rd2"},  READ_DATA_2_OUT, v.rd2);
    check({v.name, ".imm"},  SIGN_EXT_IMM_OUT, v.imm);
    check({v.name, ".rs"},   32'(RS_OUT), 32'(v.rs));
    check({v.name, ".rt"},   32'(RT_OUT), 32'(v.rt));
    check({v.name, ".rd"},   32'(RD_OUT), 32'(v.rd));
    check({v.name, ".ctrl"}, 32'(ctrl_act), 32'(v.ctrl));
  endtask

  initial begin
    //   name        ins                              we wreg wdata         fl st  rs rt rd  rd1           rd2           imm           ctrl
    add("nop_rst",   32'hFC00_0000,                   0, 0,  32'h0,        0, 0,  0, 0, 0, 32'h0,        32'h0,        32'h0,        C_NOP);
    add("add_zero",  r_ins(1, 2, 3),                  0, 0,  32'h0,        0, 0,  1, 2, 3, 32'h0,        32'h0,        32'h1820,     C_R);
    add("bypass_r5", r_ins(5, 0, 6),                  1, 5,  32'hDEADBEEF, 0, 0,  5, 0, 6, 32'hDEADBEEF, 32'h0,        32'h3020,     C_R);
    add("read_r5",   r_ins(5, 5, 7),                  0, 0,  32'h0,        0, 0,  5, 5, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'h3820,     C_R);
    add("wr_r0",     r_ins(0, 0, 8),                  1, 0,  32'h1234,     0, 0,  0, 0, 8, 32'h0,        32'h0,        32'h4020,     C_R);
    add("read_r0",   r_ins(0, 5, 9),                  0, 0,  32'h0,        0, 0,  0, 5, 9, 32'h0,        32'hDEADBEEF, 32'h4820,     C_R);
    add("addi_r1",   i_ins(6'b001000, 0, 1, 16'd5),   1, 1,  32'h100,      0, 0,  0, 1, 0, 32'h0,        32'h100,      32'h5,        C_ADDI);
    add("lw_a",      i_ins(6'b100011, 1, 2, 16'd4),   1, 3,  32'h33,       0, 0,  1, 2, 0, 32'h100,      32'h0,        32'h4,        C_LW);
    add("use_rs",    r_ins(2, 3, 4),                  0, 0,  32'h0,        0, 1,  2, 3, 4, 32'h0,        32'h33,       32'h2020,     C_NOP);
    add("use_rs_go", r_ins(2, 3, 4),                  0, 0,  32'h0,        0, 0,  2, 3, 4, 32'h0,        32'h33,       32'h2020,     C_R);
    add("lw_b",      i_ins(6'b100011, 1, 2, 16'd0),   0, 0,  32'h0,        0, 0,  1, 2, 0, 32'h100,      32'h0,        32'h0,        C_LW);
    add("addi_rt",   i_ins(6'b001000, 7, 2, 16'hFFFF),0, 0,  32'h0,        0, 0,  7, 2, 31, 32'h0,       32'h0,        32'hFFFFFFFF, C_ADDI);
    add("lw_c",      i_ins(6'b100011, 1, 2, 16'd8),   0, 0,  32'h0,        0, 0,  1, 2, 0, 32'h100,      32'h0,        32'h8,        C_LW);
    add("sw_haz_wb", i_ins(6'b101011, 3, 2, 16'd0),   1, 2,  32'h22,       0, 1,  3, 2, 0, 32'h33,       32'h22,       32'h0,        C_NOP);
    add("sw_go",     i_ins(6'b101011, 3, 2, 16'd0),   0, 0,  32'h0,        0, 0,  3, 2, 0, 32'h33,       32'h22,       32'h0,        C_SW);
    add("lw_d",      i_ins(6'b100011, 1, 2, 16'd0),   0, 0,  32'h0,        0, 0,  1, 2, 0, 32'h100,      32'h22,       32'h0,        C_LW);
    add("beq_flush", i_ins(6'b000100, 2, 0, 16'd3),   0, 0,  32'h0,        1, 0,  2, 0, 0, 32'h22,       32'h0,        32'h3,        C_NOP);
    add("beq",       i_ins(6'b000100, 1, 1, 16'hFFFE),0, 0,  32'h0,        0, 0,  1, 1, 31, 32'h100,     32'h100,      32'hFFFFFFFE, C_BEQ);
    add("sw",        i_ins(6'b101011, 0, 5, 16'd12),  0, 0,  32'h0,        0, 0,  0, 5, 0, 32'h0,        32'hDEADBEEF, 32'hC,        C_SW);
    add("bad_op",    32'hFC22_1234,                   0, 0,  32'h0,        0, 0,  1, 2, 2, 32'h100,      32'h22,       32'h1234,     C_NOP);
    add("lw_e",      i_ins(6'b100011, 1, 2, 16'd0),   0, 0,  32'h0,        0, 0,  1, 2, 0, 32'h100,      32'h22,       32'h0,        C_LW);
    add("use_rt",    r_ins(3, 2, 4),                  0, 0,  32'h0,        0, 1,  3, 2, 4, 32'h33,       32'h22,       32'h2020,     C_NOP);
    add("use_rt_go", r_ins(3, 2, 4),                  0, 0,  32'h0,        0, 0,  3, 2, 4, 32'h33,       32'h22,       32'h2020,     C_R);

    drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2 check_all_zero("in_reset");
    repeat (2) @(posedge CLK);
    #1 check_all_zero("reset_held");
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i]) apply(vecs[i], 32'h400 + 32'(4 * i));

    // Reset mid-operation with a hazard pending, then verify the register file cleared.
    @(negedge CLK);
    drive(32'h800, i_ins(6'b100011, 1, 2, 16'd0), 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    drive(32'h804, r_ins(2, 3, 4), 1'b0, 5'd0, 32'h0, 1'b0);
    #1 check("midrst.pre_stall", 32'(STALL), 32'd1);
    #1 RST_N = 1'b0;
    #1 check_all_zero("midrst.async");
    n_vec++;
    @(posedge CLK);
    #1 check_all_zero("midrst.held");
    @(negedge CLK);
    RST_N = 1'b1;
    drive(32'h808, r_ins(1, 1, 1), 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge CLK);
    #1;
    n_vec++;
    check("post_rst.ctrl", 32'(ctrl_act), 32'(C_R));
    check("post_rst.rd1",  READ_DATA_1_OUT, 32'h0);
    check("post_rst.pc",   NEXT_INS_ADR_OUT, 32'h808);
    check("post_rst.rd",   32'(RD_OUT), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
